ov7670_sccb_config: RTL
=======================

Name: ov7670_sccb_config

Overview:
- Sequences OV7670 register configuration over SCCB (3-phase write: device ID, register address, value) after power-up or a user trigger.
- Walks an external register table (synchronous ROM, 1-cycle read latency) and issues one SCCB write per entry. Handles delay entries and an end marker.
- Sits beside the pixel-capture/VGA path. DONE_O gates capture enable so frames are taken only with a configured sensor.

Parameters:
- CLK_FREQ_HZ, 25000000, frequency of CLK_I.
- SCCB_FREQ_HZ, 100000, SIOC rate. QTR = CLK_FREQ_HZ/(4*SCCB_FREQ_HZ) clocks per quarter-bit, integer division, must be >=2.
- DEV_ADDR, 8'h42, SCCB write ID.
- DELAY_CYCLES, 250000, wait inserted for a delay entry (10 ms at 25 MHz).

Ports:
- CLK_I  in  1  system clock
- RST_N  in  1  synchronous active-low reset
- START_I  in  1  level/pulse; sampled high in IDLE or DONE starts a configuration run
- ROM_ADDR_O  out  8  table address
- ROM_DATA_I  in  16  {reg[15:8], val[7:0]}, valid 1 clock after ROM_ADDR_O changes
- SIOC_O  out  1  SCCB clock
- SIOD_O  out  1  SCCB data level
- SIOD_OE_O  out  1  1 = drive SIOD_O, 0 = release (top-level tristate)
- BUSY_O  out  1  run in progress
- DONE_O  out  1  table completed; held until next START_I or reset
- REG_CNT_O  out  8  number of register writes completed in current run

Behaviour:
- Clock and reset: one clock domain, CLK_I. Reset is synchronous and active-low on RST_N, effective on the next CLK_I edge.
- Reset values: SIOC_O=1, SIOD_O=1, SIOD_OE_O=1, BUSY_O=0, DONE_O=0, ROM_ADDR_O=0, REG_CNT_O=0, state IDLE, quarter counter 0.
- Reset mid-transaction: abort immediately; bus lines go idle-high the cycle after the reset edge. No STOP is generated; the sensor resyncs on the next START condition.
- States: IDLE, FETCH, DECODE, START, BITS, STOP, GAP, DELAY, DONE.
- IDLE/DONE + START_I=1:
  - ROM_ADDR_O<=0, REG_CNT_O<=0, DONE_O<=0, BUSY_O<=1, go to FETCH.
  - START_I in any other state is ignored.
- FETCH: wait 1 clock for ROM data, then DECODE.
- DECODE on ROM_DATA_I:
  - 16'hFFFF: end marker -> DONE.
  - 16'hFFF0: -> DELAY.
  - Otherwise latch the 27-bit shift frame {DEV_ADDR,X, reg,X, val,X}, with the X bits released, then -> START.
- START (2 quarters, SIOC=1):
  - q0: SIOD=1.
  - q1: SIOD=0.
  - Then SIOC goes low on entry to BITS.
- BITS: 27 bit slots of 4 quarters each, MSB first:
  - q0–q1: SIOC=0, SIOD set at start of q0.
  - q2–q3: SIOC=1.
  - 9th bit of each byte: SIOD_OE_O=0 for all 4 quarters. ACK is not sampled.
- STOP (3 quarters):
  - SIOC=0/SIOD=0.
  - SIOC=1/SIOD=0.
  - SIOC=1/SIOD=1.
- GAP: 4 quarters bus idle (SIOC=1, SIOD=1). At end: REG_CNT_O++, ROM_ADDR_O++, -> FETCH.
- One write = 2+108+3+4 = 117 quarters.
- DELAY:
  - Bus idle for exactly DELAY_CYCLES clocks.
  - Then ROM_ADDR_O++, -> FETCH.
  - REG_CNT_O unchanged.
- Address wrap: after processing entry 255 with no end marker -> DONE. ROM_ADDR_O does not wrap to 0 and re-run.
- DONE: BUSY_O=0, DONE_O=1, bus idle.
- REG_CNT_O saturates at 255.
- Outputs are registered; SIOC/SIOD change only on quarter boundaries.

Test Plan:
- Reset: hold RST_N=0 for 5 clocks mid-BITS -> next clock SIOC_O=1, SIOD_O=1, SIOD_OE_O=1, BUSY_O=0, DONE_O=0, REG_CNT_O=0.
- Single write: CLK_FREQ_HZ=1600000 (QTR=4), table {16'h1280, 16'hFFFF}, START_I pulse:
  - Monitor decodes bytes 0x42, 0x12, 0x80.
  - 27 SIOC rising edges; SIOD_OE_O=0 during bits 9/18/27.
  - START and STOP conditions are correct.
  - DONE_O=1, REG_CNT_O=1 at 4*117 clocks + fetch/decode overhead.
- Delay entry: table {16'h1280, 16'hFFF0, 16'h1104, 16'hFFFF}, DELAY_CYCLES=100:
  - Gap between first STOP end and second START ≥ GAP+100 clocks with no SIOC toggles.
  - REG_CNT_O=2 at DONE.
- START handling:
  - START_I held high during run -> no restart; ROM_ADDR_O is monotonic.
  - START_I after DONE -> DONE_O clears next clock, ROM_ADDR_O=0, run repeats identically.
- No end marker: all 256 entries 16'h0000 -> 256 writes, REG_CNT_O=255 (saturated), DONE_O=1, ROM_ADDR_O stops at 255.

Source files
------------

// File: rtl/ov7670_sccb_config.sv
// rtl/ov7670_sccb_config.sv - OV7670 register table loader over SCCB
//
// Walks a synchronous register ROM and issues one 3-phase SCCB write per
// entry.  Entry 16'hFFF0 inserts an idle wait, 16'hFFFF ends the run.
//
// Ports:
//   CLK_I       system clock
//   RST_N       synchronous active-low reset
//   START_I     starts a run when sampled high in IDLE or DONE
//   ROM_ADDR_O  register table address
//   ROM_DATA_I  {reg, val}, valid one clock after ROM_ADDR_O changes
//   SIOC_O      SCCB clock
//   SIOD_O      SCCB data level
//   SIOD_OE_O   1 = drive SIOD_O, 0 = release
//   BUSY_O      run in progress
//   DONE_O      table completed, held until next start or reset
//   REG_CNT_O   register writes completed in this run (saturating)
module ov7670_sccb_config #(
  parameter int         CLK_FREQ_HZ  = 25000000,
  parameter int         SCCB_FREQ_HZ = 100000,
  parameter logic [7:0] DEV_ADDR     = 8'h42,
  parameter int         DELAY_CYCLES = 250000
) (
  input  logic        CLK_I,
  input  logic        RST_N,
  input  logic        START_I,
  output logic [7:0]  ROM_ADDR_O,
  input  logic [15:0] ROM_DATA_I,
  output logic        SIOC_O,
  output logic        SIOD_O,
  output logic        SIOD_OE_O,
  output logic        BUSY_O,
  output logic        DONE_O,
  output logic [7:0]  REG_CNT_O
);

  localparam int QTR = CLK_FREQ_HZ / (4 * SCCB_FREQ_HZ);
  localparam int QW  = (QTR > 1) ? $clog2(QTR) : 1;
  localparam int DW  = $clog2(DELAY_CYCLES + 1);
  localparam logic [QW-1:0] Q_LAST = QW'(QTR - 1);
  localparam logic [DW-1:0] D_LAST = DW'(DELAY_CYCLES - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_START, S_BITS, S_STOP, S_GAP, S_DELAY, S_DONE
  } state_t;

  state_t         state;
  logic [QW-1:0]  qcnt;
  logic [1:0]     qidx;
  logic [4:0]     bit_idx;
  logic [26:0]    frame;
  logic [DW-1:0]  dcnt;

  logic q_end;
  logic timed;
  logic last_entry;

  assign q_end      = (qcnt == Q_LAST);
  assign timed      = (state == S_START) || (state == S_BITS) ||
                      (state == S_STOP)  || (state == S_GAP);
  assign last_entry = (ROM_ADDR_O == 8'hFF);

  // Slots 8, 17 and 26 are the don't-care (ACK) bits of each byte.
  function automatic logic is_ack(input logic [4:0] b);
    return (b == 5'd8) || (b == 5'd17) || (b == 5'd26);
  endfunction

  always_ff @(posedge CLK_I) begin
    if (!RST_N) begin
      state      <= S_IDLE;
      qcnt       <= '0;
      qidx       <= 2'd0;
      bit_idx    <= 5'd0;
      frame      <= '0;
      dcnt       <= '0;
      ROM_ADDR_O <= 8'd0;
      REG_CNT_O  <= 8'd0;
      SIOC_O     <= 1'b1;
      SIOD_O     <= 1'b1;
      SIOD_OE_O  <= 1'b1;
      BUSY_O     <= 1'b0;
      DONE_O     <= 1'b0;
    end else begin
      // Quarter-bit timebase runs only while a write is on the bus.
      if (timed && !q_end)
        qcnt <= qcnt + 1'b1;
      else
        qcnt <= '0;

      case (state)
        S_IDLE, S_DONE: begin
          if (START_I) begin
            ROM_ADDR_O <= 8'd0;
            REG_CNT_O  <= 8'd0;
            DONE_O     <= 1'b0;
            BUSY_O     <= 1'b1;
            state      <= S_FETCH;
          end
        end

        S_FETCH: state <= S_DECODE;

        S_DECODE: begin
          qidx <= 2'd0;
          if (ROM_DATA_I == 16'hFFFF) begin
            BUSY_O <= 1'b0;
            DONE_O <= 1'b1;
            state  <= S_DONE;
          end else if (ROM_DATA_I == 16'hFFF0) begin
            dcnt  <= '0;
            state <= S_DELAY;
          end else begin
            frame     <= {DEV_ADDR, 1'b1, ROM_DATA_I[15:8], 1'b1, ROM_DATA_I[7:0], 1'b1};
            SIOC_O    <= 1'b1;
            SIOD_O    <= 1'b1;
            SIOD_OE_O <= 1'b1;
            state     <= S_START;
          end
        end

        S_START: begin
          if (q_end) begin
            if (qidx == 2'd0) begin
              SIOD_O <= 1'b0;
              qidx   <= 2'd1;
            end else begin
              SIOC_O    <= 1'b0;
              SIOD_O    <= frame[26];
              SIOD_OE_O <= 1'b1;
              bit_idx   <= 5'd0;
              qidx      <= 2'd0;
              state     <= S_BITS;
            end
          end
        end

        S_BITS: begin
          if (q_end) begin
            qidx <= qidx + 2'd1;
            case (qidx)
              2'd1: SIOC_O <= 1'b1;
              2'd3: begin
                SIOC_O <= 1'b0;
                if (bit_idx == 5'd26) begin
                  SIOD_O    <= 1'b0;
                  SIOD_OE_O <= 1'b1;
                  state     <= S_STOP;
                end else begin
                  // frame[26] is always the bit on the wire; shift in the next.
                  frame     <= {frame[25:0], 1'b0};
                  SIOD_O    <= frame[25];
                  SIOD_OE_O <= !is_ack(bit_idx + 5'd1);
                  bit_idx   <= bit_idx + 5'd1;
                end
              end
              default: ;
            endcase
          end
        end

        S_STOP: begin
          if (q_end) begin
            qidx <= qidx + 2'd1;
            case (qidx)
              2'd0: SIOC_O <= 1'b1;
              2'd1: SIOD_O <= 1'b1;
              default: begin
                qidx  <= 2'd0;
                state <= S_GAP;
              end
            endcase
          end
        end

        S_GAP: begin
          if (q_end) begin
            qidx <= qidx + 2'd1;
            if (qidx == 2'd3) begin
              if (REG_CNT_O != 8'hFF)
                REG_CNT_O <= REG_CNT_O + 8'd1;
              if (last_entry) begin
                BUSY_O <= 1'b0;
                DONE_O <= 1'b1;
                state  <= S_DONE;
              end else begin
                ROM_ADDR_O <= ROM_ADDR_O + 8'd1;
                state      <= S_FETCH;
              end
            end
          end
        end

        S_DELAY: begin
          if (dcnt == D_LAST) begin
            if (last_entry) begin
              BUSY_O <= 1'b0;
              DONE_O <= 1'b1;
              state  <= S_DONE;
            end else begin
              ROM_ADDR_O <= ROM_ADDR_O + 8'd1;
              state      <= S_FETCH;
            end
          end else begin
            dcnt <= dcnt + 1'b1;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
